cacheline_burst_adapter: RTL and testbench

//  Converts single 256-bit cacheline fill/writeback requests from the cache controllers

---
 rtl/cacheline_burst_adapter_if.sv | 43 ++++
 rtl/cacheline_burst_adapter.sv | 103 ++++++++++
 tb/tb_cacheline_burst_adapter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adapter_if.sv
// rtl/cacheline_burst_adapter_if.sv - cache-side and banked-memory-side bus bundle
// Purpose: groups the cacheline request port (dfp_*) and the 64-bit burst port
//          (bmem_*) of cacheline_burst_adapter into one interface.
// Ports (signals):
//   dfp_addr/dfp_read/dfp_write/dfp_wdata  cache line request, into the adapter
//   dfp_rdata/dfp_resp                     assembled fill line and completion pulse
//   bmem_addr/bmem_read/bmem_write/bmem_wdata  burst request and write beats
//   bmem_ready/bmem_raddr/bmem_rdata/bmem_rvalid  memory handshake and read beats
// Modports: slave = adapter view, master = cache/memory environment view.
interface cacheline_burst_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// rtl/cacheline_burst_adapter.sv - 256-bit cacheline to 4-beat 64-bit burst adapter
// Purpose: turns one line fill into a read burst whose beats are assembled into a
//          line, and one line writeback into four serialised write beats.
// Ports:
//   clk    clock, all state changes on posedge
//   rst_n  synchronous active-low reset; abandons any burst in flight
//   bus    cacheline_burst_adapter_if.slave (dfp_* cache side, bmem_* memory side)
module cacheline_burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  cacheline_burst_adapter_if.slave bus
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-within-line offset bits of the request address.
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_W / 8) - 32'd1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_REQ   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
      wline    <= '0;
      line_buf <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Read has priority; a concurrent write stays pending at the cache.
          if (bus.dfp_read) begin
            addr_q <= bus.dfp_addr & ALIGN_MASK;
            state  <= RD_REQ;
          end else if (bus.dfp_write) begin
            addr_q   <= bus.dfp_addr & ALIGN_MASK;
            wline    <= bus.dfp_wdata;
            beat_cnt <= '0;
            state    <= WR_BURST;
          end
        end
        RD_REQ: begin
          if (bus.bmem_ready) begin
            beat_cnt <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Beats tagged with another burst's address are dropped.
          if (bus.bmem_rvalid && (bus.bmem_raddr == addr_q)) begin
            line_buf[beat_cnt*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              // Last beat goes straight into the output line so dfp_rdata is
              // valid in the same cycle dfp_resp pulses; the previous fill line
              // is held until then.
              rdata_q <= {bus.bmem_rdata, line_buf[LINE_W-BEAT_W-1:0]};
              state   <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (bus.bmem_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bmem_read  = (state == RD_REQ);
  assign bus.bmem_write = (state == WR_BURST);
  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_wdata = (state == WR_BURST) ? wline[beat_cnt*BEAT_W +: BEAT_W] : '0;
  assign bus.dfp_resp   = (state == DONE);
  assign bus.dfp_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb/tb_cacheline_burst_adapter.sv - directed self-checking bench for cacheline_burst_adapter
module tb_cacheline_burst_adapter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  bit   monitor_on;

  cacheline_burst_adapter_if #(.LINE_W(256), .BEAT_W(64)) bif ();

  cacheline_burst_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [63:0] d);
    bif.bmem_rvalid = 1'b1;
    bif.bmem_raddr  = a;
    bif.bmem_rdata  = d;
    tick();
    bif.bmem_rvalid = 1'b0;
  endtask

  // dfp_resp must never coincide with a bmem request or write beat.
  always @(negedge clk) begin
    if (monitor_on && rst_n === 1'b1)
      check("resp_excl", {255'd0, bif.dfp_resp & (bif.bmem_read | bif.bmem_write)}, 256'd0);
  end

  logic [63:0]  a0, a1, a2, a3, w0, w1, w2, w3;
  logic [63:0]  wexp [6];
  logic [5:0]   rdy_pat;
  logic [255:0] line1, line3;

  initial begin
    n_checks = 0;
    n_fail = 0;
    monitor_on = 1'b0;
    rst_n = 1'b0;
    bif.dfp_addr = '0;
    bif.dfp_read = 1'b0;
    bif.dfp_write = 1'b0;
    bif.dfp_wdata = '0;
    bif.bmem_ready = 1'b0;
    bif.bmem_raddr = '0;
    bif.bmem_rdata = '0;
    bif.bmem_rvalid = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_rdata", bif.dfp_rdata, 256'd0);
    check("rst_resp", {255'd0, bif.dfp_resp}, 256'd0);
    check("rst_bread", {255'd0, bif.bmem_read}, 256'd0);
    check("rst_bwrite", {255'd0, bif.bmem_write}, 256'd0);
    check("rst_baddr", {224'd0, bif.bmem_addr}, 256'd0);
    check("rst_bwdata", {192'd0, bif.bmem_wdata}, 256'd0);
    rst_n = 1'b1;
    monitor_on = 1'b1;
    tick();

    // 1: read 0x1234, consecutive beats
    bif.dfp_read = 1'b1;
    bif.dfp_addr = 32'h0000_1234;
    bif.bmem_ready = 1'b1;
    tick();
    check("t1_bread", {255'd0, bif.bmem_read}, 256'd1);
    check("t1_baddr", {224'd0, bif.bmem_addr}, {224'd0, 32'h0000_1220});
    tick();
    check("t1_bread_drop", {255'd0, bif.bmem_read}, 256'd0);
    beat(32'h0000_1220, 64'h0000_0000_0000_0000);
    beat(32'h0000_1220, 64'h1111_1111_1111_1111);
    beat(32'h0000_1220, 64'h2222_2222_2222_2222);
    check("t1_no_early_resp", {255'd0, bif.dfp_resp}, 256'd0);
    beat(32'h0000_1220, 64'h3333_3333_3333_3333);
    line1 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    check("t1_resp", {255'd0, bif.dfp_resp}, 256'd1);
    check("t1_rdata", bif.dfp_rdata, line1);
    bif.dfp_read = 1'b0;
    tick();
    check("t1_resp_pulse", {255'd0, bif.dfp_resp}, 256'd0);
    check("t1_rdata_hold", bif.dfp_rdata, line1);

    // 2: write 0x8000_0040, ready pattern 1,0,1,1,0,1
    a0 = 64'hA0A0_0000_0000_00A0;
    a1 = 64'hA1A1_1111_1111_11A1;
    a2 = 64'hA2A2_2222_2222_22A2;
    a3 = 64'hA3A3_3333_3333_33A3;
    wexp[0] = a0; wexp[1] = a1; wexp[2] = a1;
    wexp[3] = a2; wexp[4] = a3; wexp[5] = a3;
    rdy_pat = 6'b101101;
    bif.dfp_write = 1'b1;
    bif.dfp_addr = 32'h8000_0040;
    bif.dfp_wdata = {a3, a2, a1, a0};
    tick();
    // Post-acceptance changes must not leak into the burst.
    bif.dfp_addr = 32'hFFFF_FFFF;
    bif.dfp_wdata = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    for (int i = 0; i < 6; i++) begin
      bif.bmem_ready = rdy_pat[i];
      check("t2_bwrite", {255'd0, bif.bmem_write}, 256'd1);
      check("t2_baddr", {224'd0, bif.bmem_addr}, {224'd0, 32'h8000_0040});
      check("t2_wdata", {192'd0, bif.bmem_wdata}, {192'd0, wexp[i]});
      tick();
    end
    check("t2_resp", {255'd0, bif.dfp_resp}, 256'd1);
    check("t2_bwrite_drop", {255'd0, bif.bmem_write}, 256'd0);
    check("t2_rdata_kept", bif.dfp_rdata, line1);
    bif.dfp_write = 1'b0;
    bif.bmem_ready = 1'b1;
    tick();
    check("t2_resp_pulse", {255'd0, bif.dfp_resp}, 256'd0);

    // 3: read with a stray beat; RD_REQ held one cycle by ready=0
    bif.dfp_read = 1'b1;
    bif.dfp_addr = 32'h0000_201F;
    bif.bmem_ready = 1'b0;
    tick();
    tick();
    check("t3_req_hold", {255'd0, bif.bmem_read}, 256'd1);
    check("t3_baddr", {224'd0, bif.bmem_addr}, {224'd0, 32'h0000_2000});
    bif.bmem_ready = 1'b1;
    tick();
    beat(32'h0000_2000, 64'hB000_0000_0000_0000);
    beat(32'h0000_2000, 64'hB111_1111_1111_1111);
    beat(32'hDEAD_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    beat(32'h0000_2000, 64'hB222_2222_2222_2222);
    check("t3_no_early_resp", {255'd0, bif.dfp_resp}, 256'd0);
    beat(32'h0000_2000, 64'hB333_3333_3333_3333);
    line3 = {64'hB333_3333_3333_3333, 64'hB222_2222_2222_2222,
             64'hB111_1111_1111_1111, 64'hB000_0000_0000_0000};
    check("t3_resp", {255'd0, bif.dfp_resp}, 256'd1);
    check("t3_rdata", bif.dfp_rdata, line3);
    bif.dfp_read = 1'b0;
    tick();

    // 4: reset after two beats of a read; late beats ignored
    bif.dfp_read = 1'b1;
    bif.dfp_addr = 32'h0000_3000;
    tick();
    tick();
    beat(32'h0000_3000, 64'hC000_0000_0000_0000);
    beat(32'h0000_3000, 64'hC111_1111_1111_1111);
    rst_n = 1'b0;
    beat(32'h0000_3000, 64'hC222_2222_2222_2222);
    check("t4_rdata", bif.dfp_rdata, 256'd0);
    check("t4_resp", {255'd0, bif.dfp_resp}, 256'd0);
    check("t4_bread", {255'd0, bif.bmem_read}, 256'd0);
    check("t4_baddr", {224'd0, bif.bmem_addr}, 256'd0);
    rst_n = 1'b1;
    bif.dfp_read = 1'b0;
    beat(32'h0000_3000, 64'hC333_3333_3333_3333);
    check("t4_late_resp", {255'd0, bif.dfp_resp}, 256'd0);
    check("t4_late_rdata", bif.dfp_rdata, 256'd0);
    tick();
    check("t4_idle_resp", {255'd0, bif.dfp_resp}, 256'd0);
    check("t4_idle_bread", {255'd0, bif.bmem_read}, 256'd0);
    bif.dfp_read = 1'b1;
    tick();
    check("t4_rerun_bread", {255'd0, bif.bmem_read}, 256'd1);
    tick();
    beat(32'h0000_3000, 64'hE000_0000_0000_0000);
    beat(32'h0000_3000, 64'hE111_1111_1111_1111);
    beat(32'h0000_3000, 64'hE222_2222_2222_2222);
    beat(32'h0000_3000, 64'hE333_3333_3333_3333);
    check("t4_rerun_resp", {255'd0, bif.dfp_resp}, 256'd1);
    check("t4_rerun_rdata", bif.dfp_rdata,
          {64'hE333_3333_3333_3333, 64'hE222_2222_2222_2222,
           64'hE111_1111_1111_1111, 64'hE000_0000_0000_0000});
    bif.dfp_read = 1'b0;
    tick();

    // 5: read and write together -> read first, then the write
    w0 = 64'h5000_0000_0000_0050;
    w1 = 64'h5111_1111_1111_1151;
    w2 = 64'h5222_2222_2222_2252;
    w3 = 64'h5333_3333_3333_3353;
    bif.dfp_read = 1'b1;
    bif.dfp_write = 1'b1;
    bif.dfp_addr = 32'h0000_4000;
    bif.dfp_wdata = {w3, w2, w1, w0};
    tick();
    check("t5_read_first", {254'd0, bif.bmem_read, bif.bmem_write}, 256'd2);
    tick();
    beat(32'h0000_4000, 64'hF000_0000_0000_0000);
    beat(32'h0000_4000, 64'hF111_1111_1111_1111);
    beat(32'h0000_4000, 64'hF222_2222_2222_2222);
    beat(32'h0000_4000, 64'hF333_3333_3333_3333);
    check("t5_rd_resp", {255'd0, bif.dfp_resp}, 256'd1);
    check("t5_rdata", bif.dfp_rdata,
          {64'hF333_3333_3333_3333, 64'hF222_2222_2222_2222,
           64'hF111_1111_1111_1111, 64'hF000_0000_0000_0000});
    bif.dfp_read = 1'b0;
    tick();
    check("t5_idle_bwrite", {255'd0, bif.bmem_write}, 256'd0);
    tick();
    check("t5_wr_start", {255'd0, bif.bmem_write}, 256'd1);
    check("t5_wd0", {192'd0, bif.bmem_wdata}, {192'd0, w0});
    tick();
    check("t5_wd1", {192'd0, bif.bmem_wdata}, {192'd0, w1});
    tick();
    check("t5_wd2", {192'd0, bif.bmem_wdata}, {192'd0, w2});
    tick();
    check("t5_wd3", {192'd0, bif.bmem_wdata}, {192'd0, w3});
    tick();
    check("t5_wr_resp", {255'd0, bif.dfp_resp}, 256'd1);
    bif.dfp_write = 1'b0;
    tick();

    // 6: read held past dfp_resp -> second burst to same aligned address
    bif.dfp_read = 1'b1;
    bif.dfp_addr = 32'h0000_5008;
    tick();
    tick();
    beat(32'h0000_5000, 64'h6000_0000_0000_0000);
    beat(32'h0000_5000, 64'h6111_1111_1111_1111);
    beat(32'h0000_5000, 64'h6222_2222_2222_2222);
    beat(32'h0000_5000, 64'h6333_3333_3333_3333);
    check("t6_resp", {255'd0, bif.dfp_resp}, 256'd1);
    tick();
    check("t6_idle_bread", {255'd0, bif.bmem_read}, 256'd0);
    tick();
    bif.dfp_read = 1'b0;
    check("t6_second_bread", {255'd0, bif.bmem_read}, 256'd1);
    check("t6_second_baddr", {224'd0, bif.bmem_addr}, {224'd0, 32'h0000_5000});
    tick();
    beat(32'h0000_5000, 64'h7000_0000_0000_0000);
    beat(32'h0000_5000, 64'h7111_1111_1111_1111);
    beat(32'h0000_5000, 64'h7222_2222_2222_2222);
    beat(32'h0000_5000, 64'h7333_3333_3333_3333);
    check("t6_second_resp", {255'd0, bif.dfp_resp}, 256'd1);
    check("t6_second_rdata", bif.dfp_rdata,
          {64'h7333_3333_3333_3333, 64'h7222_2222_2222_2222,
           64'h7111_1111_1111_1111, 64'h7000_0000_0000_0000});
    tick();
    check("t6_final_resp", {255'd0, bif.dfp_resp}, 256'd0);

    monitor_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
